// File: rtl/udp_tx_arbiter.sv
// Two-requester packet arbiter in front of UDP_TX: holds a grant for a whole
// AXI-Stream packet, inserts one idle cycle between packets, counts packets per port.
module udp_tx_arbiter #(
   parameter int P_RR_EN = 1,
   parameter int P_CNT_W = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [63:0]        s0_axis_user_data,
   input  logic [31:0]        s0_axis_user_user,
   input  logic [7:0]         s0_axis_user_keep,
   input  logic               s0_axis_user_last,
   input  logic               s0_axis_user_valid,
   output logic               s0_axis_user_ready,
   input  logic [63:0]        s1_axis_user_data,
   input  logic [31:0]        s1_axis_user_user,
   input  logic [7:0]         s1_axis_user_keep,
   input  logic               s1_axis_user_last,
   input  logic               s1_axis_user_valid,
   output logic               s1_axis_user_ready,
   output logic [63:0]        m_axis_user_data,
   output logic [31:0]        m_axis_user_user,
   output logic [7:0]         m_axis_user_keep,
   output logic               m_axis_user_last,
   output logic               m_axis_user_valid,
   input  logic               m_axis_user_ready,
   output logic [1:0]         o_grant,
   output logic [P_CNT_W-1:0] o_pkt_cnt0,
   output logic [P_CNT_W-1:0] o_pkt_cnt1
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   localparam logic [P_CNT_W-1:0] LP_ONE = 1;

   state_t               r_state;
   logic                 r_lastServed;
   logic [1:0]           r_grant;
   logic [P_CNT_W-1:0]   r_cnt0;
   logic [P_CNT_W-1:0]   r_cnt1;
   logic                 w_pick1;
   logic                 w_done0;
   logic                 w_done1;

   // Port 1 wins alone, or in round-robin mode when port 0 was served last
   assign w_pick1 = s1_axis_user_valid &
                    (~s0_axis_user_valid | ((P_RR_EN != 0) & ~r_lastServed));

   assign w_done0 = s0_axis_user_valid & m_axis_user_ready & s0_axis_user_last;
   assign w_done1 = s1_axis_user_valid & m_axis_user_ready & s1_axis_user_last;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_lastServed <= 1'b1;
         r_grant      <= 2'b00;
         r_cnt0       <= '0;
         r_cnt1       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (s0_axis_user_valid | s1_axis_user_valid) begin
                  if (w_pick1) begin
                     r_state      <= GNT1;
                     r_grant      <= 2'b10;
                     r_lastServed <= 1'b1;
                  end else begin
                     r_state      <= GNT0;
                     r_grant      <= 2'b01;
                     r_lastServed <= 1'b0;
                  end
               end
            end
            GNT0: begin
               if (w_done0) begin
                  r_state <= IDLE;
                  r_grant <= 2'b00;
                  r_cnt0  <= r_cnt0 + LP_ONE;
               end
            end
            GNT1: begin
               if (w_done1) begin
                  r_state <= IDLE;
                  r_grant <= 2'b00;
                  r_cnt1  <= r_cnt1 + LP_ONE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_grant <= 2'b00;
            end
         endcase
      end
   end

   // Zero-latency datapath: only the granted port is ever routed to the master
   always_comb begin
      m_axis_user_data   = '0;
      m_axis_user_user   = '0;
      m_axis_user_keep   = '0;
      m_axis_user_last   = 1'b0;
      m_axis_user_valid  = 1'b0;
      s0_axis_user_ready = 1'b0;
      s1_axis_user_ready = 1'b0;
      case (r_state)
         GNT0: begin
            m_axis_user_data   = s0_axis_user_data;
            m_axis_user_user   = s0_axis_user_user;
            m_axis_user_keep   = s0_axis_user_keep;
            m_axis_user_last   = s0_axis_user_last;
            m_axis_user_valid  = s0_axis_user_valid;
            s0_axis_user_ready = m_axis_user_ready;
         end
         GNT1: begin
            m_axis_user_data   = s1_axis_user_data;
            m_axis_user_user   = s1_axis_user_user;
            m_axis_user_keep   = s1_axis_user_keep;
            m_axis_user_last   = s1_axis_user_last;
            m_axis_user_valid  = s1_axis_user_valid;
            s1_axis_user_ready = m_axis_user_ready;
         end
         default: begin
         end
      endcase
   end

   assign o_grant    = r_grant;
   assign o_pkt_cnt0 = r_cnt0;
   assign o_pkt_cnt1 = r_cnt1;

endmodule
